// File: rtl/blood_pkg.sv
// rtl/blood_pkg.sv - shared constants for the blood splatter sprite renderer
package blood_pkg;

  localparam int SPRITE_W    = 64;
  localparam int SPRITE_HALF = 32;

  localparam logic [11:0] TRANSPARENT = 12'h000;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_SHOW = 1'b1;

endpackage

// File: rtl/blood_origin_clamp.sv
// rtl/blood_origin_clamp.sv - keeps a 64-pixel sprite origin fully on screen along one axis
module blood_origin_clamp
  import blood_pkg::*;
#(
  parameter int M = 640
) (
  input  logic [9:0] i_c,
  output logic [9:0] o_origin
);

  localparam logic [10:0] HI_LIMIT = 11'(M - SPRITE_HALF);
  localparam logic [9:0]  HI_ORG   = 10'(M - SPRITE_W);

  // Centre near an edge pins the sprite to that edge, otherwise centre it
  always_comb begin
    if ({1'b0, i_c} < 11'(SPRITE_HALF)) begin
      o_origin = '0;
    end else if ({1'b0, i_c} > HI_LIMIT) begin
      o_origin = HI_ORG;
    end else begin
      o_origin = i_c - 10'(SPRITE_HALF);
    end
  end

endmodule

// File: rtl/blood_sprite_render.sv
// rtl/blood_sprite_render.sv - timed 64x64 blood splatter overlay driven by an external ROM
module blood_sprite_render
  import blood_pkg::*;
#(
  parameter int H_MAX    = 640,
  parameter int V_MAX    = 480,
  parameter int DURATION = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hit,
  input  logic [9:0]  hit_x,
  input  logic [9:0]  hit_y,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        frame_tick,
  output logic [5:0]  rom_row,
  output logic [5:0]  rom_col,
  input  logic [11:0] rom_color,
  output logic        blood_on,
  output logic [11:0] blood_rgb,
  output logic        busy
);

  localparam int          FW  = $clog2(DURATION + 1);
  localparam logic [FW-1:0] DUR = FW'(DURATION);

  state_t        r_state;
  logic [FW-1:0] r_fcnt;
  logic [9:0]    r_ox;
  logic [9:0]    r_oy;
  logic          r_inside_d;

  logic [9:0]    w_ox_next;
  logic [9:0]    w_oy_next;
  logic          w_in_x;
  logic          w_in_y;
  logic          w_inside;

  blood_origin_clamp #(.M(H_MAX)) u_clamp_x (
    .i_c      (hit_x),
    .o_origin (w_ox_next)
  );

  blood_origin_clamp #(.M(V_MAX)) u_clamp_y (
    .i_c      (hit_y),
    .o_origin (w_oy_next)
  );

  // Hit (re)arms the splatter and wins over a same-cycle frame tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_fcnt  <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
    end else if (hit) begin
      r_state <= ST_SHOW;
      r_fcnt  <= DUR;
      r_ox    <= w_ox_next;
      r_oy    <= w_oy_next;
    end else if (r_state == ST_SHOW && frame_tick) begin
      r_fcnt <= r_fcnt - FW'(1);
      if (r_fcnt == FW'(1)) begin
        r_state <= ST_IDLE;
      end
    end
  end

  // Window test in 11 bits so ox+64 never wraps at the screen edge
  always_comb begin
    w_in_x   = ({1'b0, x} >= {1'b0, r_ox}) && ({1'b0, x} < ({1'b0, r_ox} + 11'(SPRITE_W)));
    w_in_y   = ({1'b0, y} >= {1'b0, r_oy}) && ({1'b0, y} < ({1'b0, r_oy} + 11'(SPRITE_W)));
    w_inside = (r_state == ST_SHOW) && video_on && w_in_x && w_in_y;
    rom_row  = w_inside ? (y[5:0] - r_oy[5:0]) : 6'd0;
    rom_col  = w_inside ? (x[5:0] - r_ox[5:0]) : 6'd0;
  end

  // Delay the window flag to line up with the ROM read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inside_d <= 1'b0;
    end else begin
      r_inside_d <= w_inside;
    end
  end

  // Black texels are holes in the splatter
  always_comb begin
    blood_on  = r_inside_d && (rom_color != TRANSPARENT);
    blood_rgb = blood_on ? rom_color : TRANSPARENT;
    busy      = (r_state == ST_SHOW);
  end

endmodule

// File: tb/tb_blood_sprite_render.sv
// tb/tb_blood_sprite_render.sv - self-checking bench for blood_sprite_render
module tb_blood_sprite_render;

  logic        clk = 1'b0;
  logic        reset;
  logic        hit;
  logic [9:0]  hit_x;
  logic [9:0]  hit_y;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic        frame_tick;
  logic [5:0]  rom_row;
  logic [5:0]  rom_col;
  logic [11:0] rom_color = 12'h000;
  logic        blood_on;
  logic [11:0] blood_rgb;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [9:0]  hx;
    logic [9:0]  hy;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        vo;
    logic [5:0]  row;
    logic [5:0]  col;
    logic        on;
    logic [11:0] rgb;
  } vec_t;

  typedef struct {
    logic        on;
    logic [11:0] rgb;
  } exp_t;

  vec_t vecs[14];
  exp_t sb_q[$];

  blood_sprite_render #(.H_MAX(640), .V_MAX(480), .DURATION(30)) dut (
    .clk        (clk),
    .reset      (reset),
    .hit        (hit),
    .hit_x      (hit_x),
    .hit_y      (hit_y),
    .x          (x),
    .y          (y),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .rom_row    (rom_row),
    .rom_col    (rom_col),
    .rom_color  (rom_color),
    .blood_on   (blood_on),
    .blood_rgb  (blood_rgb),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Bench ROM: one transparent texel at (3,3), red everywhere else
  always @(posedge clk) begin
    rom_color <= (rom_row == 6'd3 && rom_col == 6'd3) ? 12'h000 : 12'hE00;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("blood_on", {31'd0, blood_on}, {31'd0, e.on});
      chk("blood_rgb", {20'd0, blood_rgb}, {20'd0, e.rgb});
    end
  endtask

  task automatic do_hit(input logic [9:0] hx, input logic [9:0] hy);
    hit   = 1'b1;
    hit_x = hx;
    hit_y = hy;
    step();
    hit = 1'b0;
  endtask

  task automatic pixel(input logic [9:0] px, input logic [9:0] py, input logic vo,
                       input logic [5:0] er, input logic [5:0] ec,
                       input logic eon, input logic [11:0] ergb);
    exp_t e;
    x        = px;
    y        = py;
    video_on = vo;
    #1;
    chk("rom_row", {26'd0, rom_row}, {26'd0, er});
    chk("rom_col", {26'd0, rom_col}, {26'd0, ec});
    e.on  = eon;
    e.rgb = ergb;
    sb_q.push_back(e);
    step();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  initial begin
    // ox/oy worked by hand from the clamp rule for each hit centre
    vecs[0]  = '{10'd100, 10'd100, 10'd68,  10'd68,  1'b1, 6'd0,  6'd0,  1'b1, 12'hE00};
    vecs[1]  = '{10'd100, 10'd100, 10'd71,  10'd71,  1'b1, 6'd3,  6'd3,  1'b0, 12'h000};
    vecs[2]  = '{10'd100, 10'd100, 10'd72,  10'd71,  1'b1, 6'd3,  6'd4,  1'b1, 12'hE00};
    vecs[3]  = '{10'd100, 10'd100, 10'd71,  10'd70,  1'b1, 6'd2,  6'd3,  1'b1, 12'hE00};
    vecs[4]  = '{10'd5,   10'd470, 10'd0,   10'd416, 1'b1, 6'd0,  6'd0,  1'b1, 12'hE00};
    vecs[5]  = '{10'd5,   10'd470, 10'd63,  10'd479, 1'b1, 6'd63, 6'd63, 1'b1, 12'hE00};
    vecs[6]  = '{10'd630, 10'd10,  10'd575, 10'd0,   1'b1, 6'd0,  6'd0,  1'b0, 12'h000};
    vecs[7]  = '{10'd630, 10'd10,  10'd639, 10'd0,   1'b1, 6'd0,  6'd63, 1'b1, 12'hE00};
    vecs[8]  = '{10'd100, 10'd100, 10'd132, 10'd100, 1'b1, 6'd0,  6'd0,  1'b0, 12'h000};
    vecs[9]  = '{10'd100, 10'd100, 10'd80,  10'd80,  1'b0, 6'd0,  6'd0,  1'b0, 12'h000};
    vecs[10] = '{10'd32,  10'd32,  10'd5,   10'd7,   1'b1, 6'd7,  6'd5,  1'b1, 12'hE00};
    vecs[11] = '{10'd31,  10'd449, 10'd10,  10'd420, 1'b1, 6'd4,  6'd10, 1'b1, 12'hE00};
    vecs[12] = '{10'd608, 10'd448, 10'd576, 10'd416, 1'b1, 6'd0,  6'd0,  1'b1, 12'hE00};
    vecs[13] = '{10'd608, 10'd448, 10'd575, 10'd416, 1'b1, 6'd0,  6'd0,  1'b0, 12'h000};

    reset      = 1'b1;
    hit        = 1'b0;
    hit_x      = '0;
    hit_y      = '0;
    x          = '0;
    y          = '0;
    video_on   = 1'b0;
    frame_tick = 1'b0;
    step();
    step();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_blood_on", {31'd0, blood_on}, 32'd0);
    chk("reset_blood_rgb", {20'd0, blood_rgb}, 32'd0);
    chk("reset_rom_row", {26'd0, rom_row}, 32'd0);
    reset = 1'b0;
    step();

    // Table: hit, then one pixel; blood output checked a clock later
    for (int i = 0; i < 14; i++) begin
      do_hit(vecs[i].hx, vecs[i].hy);
      chk("hit_busy", {31'd0, busy}, 32'd1);
      pixel(vecs[i].px, vecs[i].py, vecs[i].vo, vecs[i].row, vecs[i].col, vecs[i].on, vecs[i].rgb);
      video_on = 1'b0;
      step();
    end

    // Full duration: busy through 29 ticks, gone after the 30th
    do_hit(10'd100, 10'd100);
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk($sformatf("dur_busy_tick%0d", k), {31'd0, busy}, (k < 30) ? 32'd1 : 32'd0);
    end
    pixel(10'd68, 10'd68, 1'b1, 6'd0, 6'd0, 1'b0, 12'h000);
    video_on = 1'b0;
    step();

    // Retrigger on the 10th tick: reload wins, 30 more ticks needed
    do_hit(10'd100, 10'd100);
    for (int k = 1; k <= 9; k++) tick();
    hit        = 1'b1;
    frame_tick = 1'b1;
    step();
    hit        = 1'b0;
    frame_tick = 1'b0;
    step();
    chk("retrig_busy", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 20 || k == 29 || k == 30) begin
        chk($sformatf("retrig_busy_tick%0d", k), {31'd0, busy}, (k < 30) ? 32'd1 : 32'd0);
      end
    end

    // Asynchronous reset mid-splatter, then a hit held during reset
    do_hit(10'd100, 10'd100);
    pixel(10'd68, 10'd68, 1'b1, 6'd0, 6'd0, 1'b1, 12'hE00);
    chk("pre_rst_blood_on", {31'd0, blood_on}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_blood_on", {31'd0, blood_on}, 32'd0);
    chk("async_blood_rgb", {20'd0, blood_rgb}, 32'd0);
    chk("async_rom_col", {26'd0, rom_col}, 32'd0);
    hit   = 1'b1;
    hit_x = 10'd200;
    hit_y = 10'd200;
    step();
    reset = 1'b0;
    hit   = 1'b0;
    step();
    chk("hit_in_reset_busy", {31'd0, busy}, 32'd0);
    video_on = 1'b0;
    step();

    chk("scoreboard_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
